// File: rtl/sample_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sample_ram_arbiter_if
// Brief    : Writer, burst-reader and RAM signals of the sample RAM arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface sample_ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic              rd_busy;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_done;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_len, ram_rdata,
    output rd_ack, rd_busy, rd_data_valid, rd_data, rd_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_len, ram_rdata,
    input  rd_ack, rd_busy, rd_data_valid, rd_data, rd_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/sample_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sample_ram_arbiter
// Brief    : Shares a single-port sample RAM between a queued writer and a
//            wrapping burst reader that only uses write-idle cycles.
// Revision : 1.0  initial release
// ============================================================================
module sample_ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  sample_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_q_addr [2];
  logic [DATA_W-1:0] r_q_data [2];
  logic [1:0]        r_q_cnt;
  logic              r_q_head;

  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_rd_inflight;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_ack;
  logic              r_rd_done;

  logic              w_burst_pending;
  logic              w_grant_rd;
  logic              w_grant_wr;
  logic              w_tail;
  logic              w_load;
  logic              w_ack_nxt;
  logic              w_done_nxt;

  // Grants depend on registered state only, so no input reaches the RAM port combinationally.
  assign w_burst_pending = (r_state == S_BURST) && (r_remaining != '0);
  assign w_grant_rd      = w_burst_pending && (r_q_cnt != 2'd2);
  assign w_grant_wr      = (r_q_cnt == 2'd2) || ((r_q_cnt != 2'd0) && !w_burst_pending);
  assign w_tail          = r_q_head ^ (r_q_cnt == 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ack_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rd_req) begin
          w_load      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = (bus.rd_len == '0) ? S_DRAIN : S_BURST;
        end
      end
      S_BURST: begin
        if (w_grant_rd && (r_remaining == LEN_W'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Only the final read can still be in flight here; it reaches rd_data on this edge.
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_cnt       <= 2'd0;
      r_q_head      <= 1'b0;
      r_rd_ptr      <= '0;
      r_remaining   <= '0;
      r_rd_inflight <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_rd_ack      <= 1'b0;
      r_rd_done     <= 1'b0;
    end else begin
      r_rd_ack      <= w_ack_nxt;
      r_rd_done     <= w_done_nxt;
      r_rd_inflight <= w_grant_rd;
      r_rd_valid    <= r_rd_inflight;
      if (r_rd_inflight) begin
        r_rd_data <= bus.ram_rdata;
      end
      if (w_load) begin
        r_rd_ptr    <= bus.rd_addr;
        r_remaining <= bus.rd_len;
      end else if (w_grant_rd) begin
        r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end
      r_q_head <= r_q_head ^ w_grant_wr;
      r_q_cnt  <= r_q_cnt + {1'b0, bus.wr_en} - {1'b0, w_grant_wr};
    end
  end

  // Entry storage needs no reset: nothing reads it while the count is zero.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_q_addr[w_tail] <= bus.wr_addr;
      r_q_data[w_tail] <= bus.wr_data;
    end
  end

  assign bus.ram_en        = w_grant_wr | w_grant_rd;
  assign bus.ram_we        = w_grant_wr;
  assign bus.ram_addr      = w_grant_wr ? r_q_addr[r_q_head] : (w_grant_rd ? r_rd_ptr : '0);
  assign bus.ram_wdata     = w_grant_wr ? r_q_data[r_q_head] : '0;
  assign bus.rd_ack        = r_rd_ack;
  assign bus.rd_busy       = (r_state != S_IDLE);
  assign bus.rd_data_valid = r_rd_valid;
  assign bus.rd_data       = r_rd_data;
  assign bus.rd_done       = r_rd_done;

endmodule
`default_nettype wire
